// File: rtl/bus_integrate_pkg.sv
// Shared definitions for the cache/DMA integration blocks: miss FSM encoding
// and cache-line geometry.
package bus_integrate;

  localparam int DEFAULT_LINE_WORDS = 8;

  // Byte-offset bits within a line of 32-bit words.
  function automatic int line_offset_bits(input int line_words);
    return $clog2(line_words * 4);
  endfunction

  localparam int LINE_OFFSET_W = line_offset_bits(DEFAULT_LINE_WORDS);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WB_REQ,
    ST_WB_WAIT,
    ST_WB_DRAIN,
    ST_RF_REQ,
    ST_RF_WAIT,
    ST_RF_DRAIN,
    ST_RESP,
    ST_ERR
  } miss_state_e;

  // States in which the DMA done timeout is running.
  function automatic logic is_timed_state(input miss_state_e s);
    return (s == ST_WB_WAIT) || (s == ST_WB_DRAIN) ||
           (s == ST_RF_WAIT) || (s == ST_RF_DRAIN);
  endfunction

endpackage

// File: rtl/dma_wait_timer.sv
// Saturating cycle counter bounding how long the miss controller waits on a
// DMA done level; expired flags the last allowed cycle.
module dma_wait_timer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_WIDTH       = 16
) (
  input  logic cpu_clk,
  input  logic cpu_rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_WIDTH-1:0] LIMIT = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TO_WIDTH-1:0] count;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + TO_WIDTH'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/cache_miss_ctrl.sv
// Cache miss controller: optional dirty-line write-back, then line refill,
// sequenced over the DMA happen/done handshake with a per-wait timeout.
module cache_miss_ctrl
  import bus_integrate::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int LINE_WORDS      = DEFAULT_LINE_WORDS,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int TO_WIDTH        = 16
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst_n,
  input  logic                       miss_valid,
  input  logic [ADDR_WIDTH-1:0]      miss_addr,
  input  logic                       victim_dirty,
  input  logic [ADDR_WIDTH-1:0]      victim_addr,
  output logic                       miss_ready,
  output logic                       refill_done,
  output logic                       miss_error,
  output logic                       busy,
  output logic                       dma_write_back_happen,
  output logic [ADDR_WIDTH-1:0]      dma_write_back_addr,
  output logic [BURST_LEN_WIDTH-1:0] dma_write_back_burst_len,
  input  logic                       dma_write_back_done,
  output logic                       dma_page_fault_happen,
  output logic [ADDR_WIDTH-1:0]      dma_page_fault_addr,
  output logic [BURST_LEN_WIDTH-1:0] dma_page_fault_burst_len,
  input  logic                       dma_page_fault_done
);

  localparam int OFF_W = (LINE_WORDS == DEFAULT_LINE_WORDS) ? LINE_OFFSET_W
                                                            : line_offset_bits(LINE_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));
  localparam logic [BURST_LEN_WIDTH-1:0] BURST_LEN = BURST_LEN_WIDTH'(LINE_WORDS);

  miss_state_e state, next_state;
  logic        accept;
  logic        expired;
  logic        timer_clear;
  logic        timer_enable;
  logic        dirty_q;
  logic [BURST_LEN_WIDTH-1:0] burst_q;

  assign accept     = (state == ST_IDLE) && miss_valid;
  assign miss_ready = accept && cpu_rst_n;

  // The timer restarts whenever a different wait/drain state is entered.
  assign timer_enable = is_timed_state(state);
  assign timer_clear  = is_timed_state(next_state) && (next_state != state);

  dma_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_WIDTH      (TO_WIDTH)
  ) u_timer (
    .cpu_clk  (cpu_clk),
    .cpu_rst_n(cpu_rst_n),
    .clear    (timer_clear),
    .enable   (timer_enable),
    .expired  (expired)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (miss_valid) next_state = victim_dirty ? ST_WB_REQ : ST_RF_REQ;
      ST_WB_REQ:   next_state = dirty_q ? ST_WB_WAIT : ST_RF_REQ;
      ST_WB_WAIT:  if (expired) next_state = ST_ERR;
                   else if (dma_write_back_done) next_state = ST_WB_DRAIN;
      ST_WB_DRAIN: if (expired) next_state = ST_ERR;
                   else if (!dma_write_back_done) next_state = ST_RF_REQ;
      ST_RF_REQ:   next_state = ST_RF_WAIT;
      ST_RF_WAIT:  if (expired) next_state = ST_ERR;
                   else if (dma_page_fault_done) next_state = ST_RF_DRAIN;
      ST_RF_DRAIN: if (expired) next_state = ST_ERR;
                   else if (!dma_page_fault_done) next_state = ST_RESP;
      ST_RESP:     next_state = ST_IDLE;
      ST_ERR:      next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) state <= ST_IDLE;
    else            state <= next_state;
  end

  // Strobes are registered off next_state so they line up with the state.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      busy                  <= 1'b0;
      dma_write_back_happen <= 1'b0;
      dma_page_fault_happen <= 1'b0;
      refill_done           <= 1'b0;
      miss_error            <= 1'b0;
      dma_write_back_addr   <= '0;
      dma_page_fault_addr   <= '0;
      dirty_q               <= 1'b0;
      burst_q               <= '0;
    end else begin
      busy                  <= (next_state != ST_IDLE);
      dma_write_back_happen <= (next_state == ST_WB_REQ);
      dma_page_fault_happen <= (next_state == ST_RF_REQ);
      refill_done           <= (next_state == ST_RESP);
      miss_error            <= (next_state == ST_ERR);
      if (accept) begin
        dma_write_back_addr <= victim_addr & LINE_MASK;
        dma_page_fault_addr <= miss_addr & LINE_MASK;
        dirty_q             <= victim_dirty;
        burst_q             <= BURST_LEN;
      end
    end
  end

  assign dma_write_back_burst_len = burst_q;
  assign dma_page_fault_burst_len = burst_q;

endmodule
